// File: rtl/inst_fetch.sv
// Instruction fetch/prefetch: streams words from sync-read memory into a small FIFO until HALT.
// Optional INST_FETCH_BYPASS_EN forwards returning data straight to the output when the FIFO is empty.
module inst_fetch #(
  parameter int         INST_WIDTH  = 32,
  parameter int         ADDR_WIDTH  = 10,
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read_enable,
  input  logic [INST_WIDTH-1:0] mem_data,
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] inst_data,
  input  logic                  inst_ready,
  output logic                  busy,
  output logic                  halted
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]            state;
  logic [INST_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_next;
  logic                  pending;
  logic [INST_WIDTH-1:0] head;
  logic                  fifo_empty, ret_halt, head_halt;
  logic                  bypass, bypass_take, push, fifo_pop, issue;

  assign head       = fifo_mem[rd_ptr];
  assign fifo_empty = (count == '0);
  assign ret_halt   = (mem_data[INST_WIDTH-1 -: 4] == HALT_OPCODE);
  assign head_halt  = (head[INST_WIDTH-1 -: 4] == HALT_OPCODE);

`ifdef INST_FETCH_BYPASS_EN
  assign bypass    = fifo_empty && pending && (state == FETCH);
  assign inst_data = !fifo_empty ? head : (bypass ? mem_data : '0);
`else
  assign bypass    = 1'b0;
  assign inst_data = fifo_empty ? '0 : head;
`endif

  assign inst_valid  = !fifo_empty || bypass;
  assign bypass_take = bypass && inst_ready;
  assign fifo_pop    = !fifo_empty && inst_ready;
  // Returned data is only kept while fetching; anything landing in DRAIN/IDLE is stale.
  assign push        = pending && (state == FETCH) && !bypass_take;
  assign count_next  = count + CW'(push) - CW'(fifo_pop);
  // Credit: stored words plus the read now in flight plus the new one must fit.
  assign issue       = (state == FETCH) && !(pending && ret_halt) &&
                       ((count_next + CW'(mem_read_enable)) < CW'(FIFO_DEPTH));

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      mem_addr        <= '0;
      mem_read_enable <= 1'b0;
      pending         <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      halted          <= 1'b0;
    end else if (flush) begin
      state           <= IDLE;
      mem_read_enable <= 1'b0;
      pending         <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      halted          <= 1'b0;
    end else begin
      pending         <= mem_read_enable;
      mem_read_enable <= issue;
      count           <= count_next;
      if (mem_read_enable) mem_addr <= mem_addr + ADDR_WIDTH'(1);
      if (push)            wr_ptr   <= wr_ptr + PW'(1);
      if (fifo_pop)        rd_ptr   <= rd_ptr + PW'(1);
      case (state)
        IDLE: begin
          if (start) begin
            state           <= FETCH;
            mem_addr        <= start_addr;
            mem_read_enable <= 1'b1;
            halted          <= 1'b0;
          end
        end
        FETCH: begin
          if (pending && ret_halt) begin
            state <= bypass_take ? IDLE : DRAIN;
            if (bypass_take) halted <= 1'b1;
          end
        end
        DRAIN: begin
          if (fifo_pop && head_halt) begin
            state  <= IDLE;
            halted <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: expected words queued at program load, checked on each pop.
module tb_inst_fetch;
  localparam int IW = 32;
  localparam int AW = 10;
  localparam int DEPTH = 4;
`ifdef INST_FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic reset, start, flush, inst_ready;
  logic [AW-1:0] start_addr, mem_addr;
  logic mem_read_enable, inst_valid, busy, halted;
  logic [IW-1:0] mem_data, inst_data;

  logic [IW-1:0] imem [1<<AW];
  logic [IW-1:0] exp_q [$];
  logic [AW-1:0] addr_log [$];
  int reads, checks, errors;

  always #5 clk = ~clk;

  inst_fetch #(.INST_WIDTH(IW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .HALT_OPCODE(4'hF)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .flush(flush),
    .mem_addr(mem_addr), .mem_read_enable(mem_read_enable), .mem_data(mem_data),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_ready(inst_ready),
    .busy(busy), .halted(halted));

  always @(posedge clk) begin
    mem_data <= mem_read_enable ? imem[mem_addr] : 32'h0BAD_0BAD;
    if (mem_read_enable) begin
      reads++;
      addr_log.push_back(mem_addr);
    end
  end

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; inst_ready = 1'b0; start_addr = '0;
    repeat (2) @(negedge clk);
    checks++; if (mem_addr !== '0)        begin errors++; $display("FAIL rst_mem_addr: got %h, required 0", mem_addr); end
    checks++; if (mem_read_enable !== 0) begin errors++; $display("FAIL rst_read_en: got %b, required 0", mem_read_enable); end
    checks++; if (inst_valid !== 0)      begin errors++; $display("FAIL rst_valid: got %b, required 0", inst_valid); end
    checks++; if (inst_data !== '0)      begin errors++; $display("FAIL rst_data: got %h, required 0", inst_data); end
    checks++; if (busy !== 0 || halted !== 0) begin errors++; $display("FAIL rst_busy_halted: got %b%b, required 00", busy, halted); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic(input string tag);
    int first, last, got;
    logic [IW-1:0] e;
    imem[0] = 32'h1000_0001; imem[1] = 32'h1000_0002; imem[2] = 32'hF000_0000;
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(imem[i]);
    first = -1; last = -1; got = 0;
    @(negedge clk);
    inst_ready = 1'b1; start_addr = '0; start = 1'b1; reads = 0;
    for (int k = 1; k <= 30 && got < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (inst_valid && inst_ready) begin
        if (first < 0) first = k;
        last = k; got++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL %s_extra: got %h, required no word", tag, inst_data); end
        else begin
          e = exp_q.pop_front();
          if (inst_data !== e) begin errors++; $display("FAIL %s_data: got %h, required %h", tag, inst_data, e); end
        end
      end
    end
    checks++; if (got != 3) begin errors++; $display("FAIL %s_count: got %0d words, required 3", tag, got); end
    checks++; if (first - 1 != LAT) begin errors++; $display("FAIL %s_latency: got %0d, required %0d", tag, first - 1, LAT); end
    checks++; if (last - first != 2) begin errors++; $display("FAIL %s_back_to_back: got span %0d, required 2", tag, last - first); end
    @(negedge clk);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL %s_halted: got %b, required 1", tag, halted); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL %s_busy: got %b, required 0", tag, busy); end
    repeat (3) @(negedge clk);
    checks++; if (reads < 3 || reads > 4) begin errors++; $display("FAIL %s_reads: got %0d, required 3 or 4", tag, reads); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL %s_no_stale: got valid %b, required 0", tag, inst_valid); end
  endtask

  task automatic test_backpressure();
    int first, got;
    logic [IW-1:0] e, held;
    exp_q.delete();
    for (int i = 0; i < 19; i++) imem[100+i] = 32'h1000_0000 + i;
    imem[119] = 32'hF000_0013;
    for (int i = 0; i < 20; i++) exp_q.push_back(imem[100+i]);
    first = -1; got = 0; held = '0;
    @(negedge clk);
    inst_ready = 1'b1; start_addr = 10'd100; start = 1'b1; reads = 0;
    for (int k = 1; k <= 150 && got < 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (first < 0 && inst_valid) first = k;
      inst_ready = !(first >= 0 && k < first + 10);
      if (first >= 0 && k < first + 10) begin
        checks++;
        if (reads + int'(mem_read_enable) - got > DEPTH) begin
          errors++; $display("FAIL bp_credit: got %0d outstanding+stored, required <= %0d", reads + int'(mem_read_enable) - got, DEPTH);
        end
        if (k > first) begin
          checks++;
          if (inst_valid !== 1'b1 || inst_data !== held) begin
            errors++; $display("FAIL bp_hold: got %b/%h, required 1/%h", inst_valid, inst_data, held);
          end
        end
        held = inst_data;
      end
      if (inst_valid && inst_ready) begin
        got++; checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL bp_extra: got %h, required no word", inst_data); end
        else begin
          e = exp_q.pop_front();
          if (inst_data !== e) begin errors++; $display("FAIL bp_data: got %h, required %h", inst_data, e); end
        end
      end
    end
    checks++; if (got != 20) begin errors++; $display("FAIL bp_count: got %0d words, required 20", got); end
    @(negedge clk);
    checks++; if (halted !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bp_end: got halted %b busy %b, required 1 0", halted, busy); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_wrap();
    int got;
    logic [IW-1:0] e;
    logic [AW-1:0] ea [4];
    ea[0] = 10'd1022; ea[1] = 10'd1023; ea[2] = 10'd0; ea[3] = 10'd1;
    imem[1022] = 32'h1000_03FE; imem[1023] = 32'h1000_03FF;
    imem[0] = 32'h1000_0000; imem[1] = 32'hF000_0001;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(imem[ea[i]]);
    got = 0;
    @(negedge clk);
    addr_log.delete();
    inst_ready = 1'b1; start_addr = 10'd1022; start = 1'b1;
    for (int k = 1; k <= 30 && got < 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (inst_valid && inst_ready) begin
        got++; checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL wrap_extra: got %h, required no word", inst_data); end
        else begin
          e = exp_q.pop_front();
          if (inst_data !== e) begin errors++; $display("FAIL wrap_data: got %h, required %h", inst_data, e); end
        end
      end
    end
    checks++; if (got != 4) begin errors++; $display("FAIL wrap_count: got %0d words, required 4", got); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (addr_log.size() <= i) begin errors++; $display("FAIL wrap_addr%0d: got no read, required %0d", i, ea[i]); end
      else if (addr_log[i] !== ea[i]) begin errors++; $display("FAIL wrap_addr%0d: got %0d, required %0d", i, addr_log[i], ea[i]); end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_flush();
    int got;
    logic [IW-1:0] e;
    for (int i = 0; i < 8; i++) imem[200+i] = 32'h3000_0000 + i;
    exp_q.delete();
    @(negedge clk);
    inst_ready = 1'b0; start_addr = 10'd200; start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL flush_pre: got valid %b busy %b, required 1 1", inst_valid, busy); end
    checks++; if (mem_read_enable !== 1'b0) begin errors++; $display("FAIL flush_credit_stop: got %b, required 0", mem_read_enable); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (inst_valid !== 1'b0 || inst_data !== '0) begin errors++; $display("FAIL flush_valid: got %b/%h, required 0/0", inst_valid, inst_data); end
    checks++; if (busy !== 1'b0 || mem_read_enable !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL flush_state: got busy %b rd %b halted %b, required 0 0 0", busy, mem_read_enable, halted);
    end
    imem[300] = 32'h4000_0001; imem[301] = 32'h4000_0002; imem[302] = 32'hF000_0302;
    for (int i = 0; i < 3; i++) exp_q.push_back(imem[300+i]);
    got = 0;
    inst_ready = 1'b1; start_addr = 10'd300; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (inst_valid && inst_ready) begin
        got++; checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL flush_extra: got %h, required no word", inst_data); end
        else begin
          e = exp_q.pop_front();
          if (inst_data !== e) begin errors++; $display("FAIL flush_new_data: got %h, required %h", inst_data, e); end
        end
      end
    end
    checks++; if (got != 3 || halted !== 1'b1) begin errors++; $display("FAIL flush_restart: got %0d words halted %b, required 3 1", got, halted); end
  endtask

  task automatic test_start_flush();
    int got;
    logic [IW-1:0] e;
    @(negedge clk);
    reads = 0; start_addr = 10'd50; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0 || mem_read_enable !== 1'b0) begin errors++; $display("FAIL sf_idle: got busy %b rd %b, required 0 0", busy, mem_read_enable); end
    repeat (2) @(negedge clk);
    checks++; if (reads != 0) begin errors++; $display("FAIL sf_no_read: got %0d reads, required 0", reads); end
    for (int i = 0; i < 12; i++) imem[400+i] = 32'h5000_0000 + i;
    imem[412] = 32'hF000_0412; imem[600] = 32'hF000_0600;
    exp_q.delete();
    for (int i = 0; i < 13; i++) exp_q.push_back(imem[400+i]);
    got = 0;
    addr_log.delete();
    inst_ready = 1'b1; start_addr = 10'd400; start = 1'b1;
    for (int k = 1; k <= 60 && got < 13; k++) begin
      @(negedge clk);
      start = (k == 4);
      start_addr = (k == 4) ? 10'd600 : 10'd400;
      if (inst_valid && inst_ready) begin
        got++; checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL sf_extra: got %h, required no word", inst_data); end
        else begin
          e = exp_q.pop_front();
          if (inst_data !== e) begin errors++; $display("FAIL sf_data: got %h, required %h", inst_data, e); end
        end
      end
    end
    start = 1'b0;
    checks++; if (got != 13) begin errors++; $display("FAIL sf_count: got %0d words, required 13", got); end
    for (int i = 0; i < 13; i++) begin
      checks++;
      if (addr_log.size() <= i) begin errors++; $display("FAIL sf_addr%0d: got no read, required %0d", i, 400 + i); end
      else if (addr_log[i] !== AW'(400 + i)) begin errors++; $display("FAIL sf_addr%0d: got %0d, required %0d", i, addr_log[i], 400 + i); end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) imem[500+i] = 32'h6000_0000 + i;
    exp_q.delete();
    @(negedge clk);
    inst_ready = 1'b1; start_addr = 10'd500; start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    checks++; if (mem_addr !== '0 || mem_read_enable !== 1'b0) begin errors++; $display("FAIL rmid_mem: got %h/%b, required 0/0", mem_addr, mem_read_enable); end
    checks++; if (inst_valid !== 1'b0 || inst_data !== '0) begin errors++; $display("FAIL rmid_out: got %b/%h, required 0/0", inst_valid, inst_data); end
    checks++; if (busy !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL rmid_state: got busy %b halted %b, required 0 0", busy, halted); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0 || busy !== 1'b0 || mem_read_enable !== 1'b0) begin
      errors++; $display("FAIL rmid_release: got valid %b busy %b rd %b, required 0 0 0", inst_valid, busy, mem_read_enable);
    end
    test_basic("after_reset");
  endtask

  initial begin
    checks = 0; errors = 0; reads = 0;
    for (int i = 0; i < (1 << AW); i++) imem[i] = 32'h2000_0000 + i;
    test_reset();
    test_basic("basic");
    test_backpressure();
    test_wrap();
    test_flush();
    test_start_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
